qspi_arb: RTL and testbench

//  Arbiter/sequencer in front of the qspi cache-line engine. It shares the engine between the I-cache

---
 rtl/qspi_arb_pkg.sv | 26 ++
 rtl/qspi_arb_if.sv | 65 ++++++
 rtl/qspi_arb_pick.sv | 30 +++
 rtl/qspi_arb.sv | 169 ++++++++++++++++
 tb/tb_qspi_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types for the qspi arbiter: FSM states, transaction owner and
// grant-vector bit positions.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_ISSUE,
        ST_XFER,
        ST_GUARD
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // qspi register that selects ROM/mode behaviour of the engine
    localparam logic [3:0] ROM_MODE_REG = 4'd3;

    // bit positions in the one-hot grant vector
    localparam int GNT_I   = 0;
    localparam int GNT_D   = 1;
    localparam int GNT_CFG = 2;

endpackage

// File: rtl/qspi_arb_if.sv
// Bundle of requester-side and qspi-engine-side signals around the arbiter.
// slave = arbiter view, master = requesters plus engine view.
interface qspi_arb_if #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4
);
    localparam int LA = PA - $clog2(LINE_LENGTH);

    // I-cache fill port
    logic          ic_req;
    logic [LA-1:0] ic_addr;
    logic [1:0]    ic_mem;
    logic          ic_strobe;
    logic          ic_done;
    // D-cache fill/writeback port
    logic          dc_req;
    logic          dc_write;
    logic [LA-1:0] dc_addr;
    logic [1:0]    dc_mem;
    logic          dc_rd_strobe;
    logic          dc_wr_strobe;
    logic          dc_done;
    // config register write port
    logic          cfg_req;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_data;
    logic          cfg_ack;
    // qspi engine side
    logic          q_req;
    logic          q_i_d;
    logic [1:0]    q_mem;
    logic          q_write;
    logic [LA-1:0] q_paddr;
    logic          q_wstrobe_i;
    logic          q_wstrobe_d;
    logic          q_rstrobe_d;
    logic          q_reg_write;
    logic [3:0]    q_reg_addr;
    logic [7:0]    q_reg_data;

    modport slave (
        input  ic_req, ic_addr, ic_mem,
        input  dc_req, dc_write, dc_addr, dc_mem,
        input  cfg_req, cfg_addr, cfg_data,
        input  q_wstrobe_i, q_wstrobe_d, q_rstrobe_d,
        output ic_strobe, ic_done,
        output dc_rd_strobe, dc_wr_strobe, dc_done,
        output cfg_ack,
        output q_req, q_i_d, q_mem, q_write, q_paddr,
        output q_reg_write, q_reg_addr, q_reg_data
    );

    modport master (
        output ic_req, ic_addr, ic_mem,
        output dc_req, dc_write, dc_addr, dc_mem,
        output cfg_req, cfg_addr, cfg_data,
        output q_wstrobe_i, q_wstrobe_d, q_rstrobe_d,
        input  ic_strobe, ic_done,
        input  dc_rd_strobe, dc_wr_strobe, dc_done,
        input  cfg_ack,
        input  q_req, q_i_d, q_mem, q_write, q_paddr,
        input  q_reg_write, q_reg_addr, q_reg_data
    );

endinterface

// File: rtl/qspi_arb_pick.sv
// Combinational priority picker: config first, then D unless the I side has
// been passed over STARVE_LIMIT times in a row, then I.
module qspi_arb_pick
    import qspi_pkg::*;
#(
    parameter int STARVE_LIMIT = 2,
    parameter int SW           = 2
) (
    input  logic          cfg_req,
    input  logic          dc_req,
    input  logic          ic_req,
    input  logic [SW-1:0] streak,
    output logic [2:0]    grant
);

    logic starve;

    // one-hot grant; starvation only matters while ic_req is actually pending
    always_comb begin
        grant  = '0;
        starve = ic_req && (streak >= SW'(STARVE_LIMIT));
        if (cfg_req)
            grant[GNT_CFG] = 1'b1;
        else if (dc_req && !starve)
            grant[GNT_D] = 1'b1;
        else if (ic_req)
            grant[GNT_I] = 1'b1;
    end

endmodule

// File: rtl/qspi_arb.sv
// Shares the qspi cache-line engine between I fill, D fill/writeback and
// config writes. Request fields are held for the whole transaction and
// completion is inferred by counting 2*LINE_LENGTH nibble strobes.
module qspi_arb
    import qspi_pkg::*;
#(
    parameter int PA           = 24,
    parameter int LINE_LENGTH  = 4,
    parameter int STARVE_LIMIT = 2,
    parameter int GUARD        = 2
) (
    input logic       clk,
    input logic       reset_n,
    qspi_arb_if.slave bus
);

    localparam int XLEN = 2 * LINE_LENGTH;
    localparam int CW   = $clog2(XLEN) + 1;
    localparam int GW   = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam int SW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    owner_t        owner;
    logic [CW-1:0] cnt;
    logic [GW-1:0] guard_cnt;
    logic [SW-1:0] streak;
    logic [2:0]    grant;
    logic          busy;
    logic          own_i;
    logic          own_d;
    logic          str_i;
    logic          str_dr;
    logic          str_dw;
    logic          own_strobe;

    qspi_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .cfg_req (bus.cfg_req),
        .dc_req  (bus.dc_req),
        .ic_req  (bus.ic_req),
        .streak  (streak),
        .grant   (grant)
    );

    // Strobe routing: only the owner sees strobes, and only while a
    // transaction is live. D read/write strobes are split by the held q_write.
    always_comb begin
        busy       = (state == ST_ISSUE) || (state == ST_XFER);
        own_i      = busy && (owner == OWN_I);
        own_d      = busy && (owner == OWN_D);
        str_i      = own_i && bus.q_wstrobe_i;
        str_dr     = own_d && !bus.q_write && bus.q_wstrobe_d;
        str_dw     = own_d && bus.q_write && bus.q_rstrobe_d;
        own_strobe = str_i || str_dr || str_dw;
    end

    assign bus.ic_strobe    = str_i;
    assign bus.dc_rd_strobe = str_dr;
    assign bus.dc_wr_strobe = str_dw;

    // Arbitration/sequencing FSM; every engine-facing field and done pulse is
    // registered here so it stays stable across the transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            owner           <= OWN_I;
            cnt             <= '0;
            guard_cnt       <= GW'(GUARD);
            streak          <= '0;
            bus.q_req       <= 1'b0;
            bus.q_i_d       <= 1'b0;
            bus.q_mem       <= '0;
            bus.q_write     <= 1'b0;
            bus.q_paddr     <= '0;
            bus.q_reg_write <= 1'b0;
            bus.q_reg_addr  <= '0;
            bus.q_reg_data  <= '0;
            bus.ic_done     <= 1'b0;
            bus.dc_done     <= 1'b0;
            bus.cfg_ack     <= 1'b0;
        end else begin
            // single-cycle pulses default low
            bus.ic_done     <= 1'b0;
            bus.dc_done     <= 1'b0;
            bus.cfg_ack     <= 1'b0;
            bus.q_reg_write <= 1'b0;
            // nobody is being starved once ic_req goes away
            if (!bus.ic_req)
                streak <= '0;

            case (state)
                ST_IDLE: begin
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end else if (grant[GNT_CFG]) begin
                        state           <= ST_CFG;
                        bus.q_reg_write <= 1'b1;
                        bus.cfg_ack     <= 1'b1;
                        bus.q_reg_addr  <= bus.cfg_addr;
                        bus.q_reg_data  <= bus.cfg_data;
                    end else if (grant[GNT_D]) begin
                        state       <= ST_ISSUE;
                        owner       <= OWN_D;
                        cnt         <= '0;
                        bus.q_req   <= 1'b1;
                        bus.q_i_d   <= 1'b0;
                        bus.q_mem   <= bus.dc_mem;
                        bus.q_write <= bus.dc_write;
                        bus.q_paddr <= bus.dc_addr;
                        if (bus.ic_req && (streak != SW'(STARVE_LIMIT)))
                            streak <= streak + SW'(1);
                    end else if (grant[GNT_I]) begin
                        state       <= ST_ISSUE;
                        owner       <= OWN_I;
                        cnt         <= '0;
                        bus.q_req   <= 1'b1;
                        bus.q_i_d   <= 1'b1;
                        bus.q_mem   <= bus.ic_mem;
                        bus.q_write <= 1'b0;
                        bus.q_paddr <= bus.ic_addr;
                        streak      <= '0;
                    end
                end

                ST_CFG: state <= ST_IDLE;

                // q_req held until the engine finishes power-up and strobes
                ST_ISSUE: begin
                    if (own_strobe) begin
                        bus.q_req <= 1'b0;
                        cnt       <= CW'(1);
                        state     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (own_strobe) begin
                        if (cnt == CW'(XLEN - 1)) begin
                            cnt       <= '0;
                            guard_cnt <= GW'(GUARD);
                            state     <= ST_GUARD;
                            if (owner == OWN_I)
                                bus.ic_done <= 1'b1;
                            else
                                bus.dc_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                // let the engine settle back to idle before the next q_req
                ST_GUARD: begin
                    if (guard_cnt <= GW'(1)) begin
                        guard_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb: a table of single-requester transactions plus
// hand-written sequences for arbitration order, config insertion, mid-flight
// reset and stray strobes. The bench plays both the requesters and the engine.
module tb_qspi_arb;
    import qspi_pkg::*;

    localparam int LA = 22;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    qspi_arb_if #(.PA(24), .LINE_LENGTH(4)) bus ();

    qspi_arb #(
        .PA(24), .LINE_LENGTH(4), .STARVE_LIMIT(2), .GUARD(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int regw_cnt = 0;

    // running count of cycles with q_reg_write high
    always @(posedge clk) if (bus.q_reg_write) regw_cnt <= regw_cnt + 1;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [1:0]    mem;
        logic [LA-1:0] addr;
        int            lat;
        bit            exp_i_d;
        bit            exp_wr;
        logic [1:0]    exp_mem;
        logic [LA-1:0] exp_paddr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {18'd0, bus.q_req, bus.q_i_d, bus.q_mem, bus.q_write, bus.q_paddr,
                bus.q_reg_write, bus.q_reg_addr, bus.q_reg_data,
                bus.ic_strobe, bus.ic_done, bus.dc_rd_strobe, bus.dc_wr_strobe,
                bus.dc_done, bus.cfg_ack};
    endfunction

    task automatic clear_inputs();
        bus.ic_req = 0; bus.ic_addr = '0; bus.ic_mem = '0;
        bus.dc_req = 0; bus.dc_write = 0; bus.dc_addr = '0; bus.dc_mem = '0;
        bus.cfg_req = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.q_wstrobe_i = 0; bus.q_wstrobe_d = 0; bus.q_rstrobe_d = 0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset_n = 1'b0;
        #1 check({nm, " reset outputs"}, outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // waits (bounded) for q_req; lat = negedges seen with q_req still low
    task automatic wait_qreq(input string nm, output int lat);
        bit ok = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.q_req) begin ok = 1; break; end
            lat++;
        end
        check({nm, " q_req rise"}, ok, 1);
    endtask

    // engine side of one transaction, starting on the negedge where q_req=1
    task automatic do_xfer(input string nm, input bit is_d, input bit wr, input int n,
                           input bit rerise, input bit stray);
        int   seen  = 0;
        bit   early = 0;
        logic routed;
        for (int k = 0; k < n; k++) begin
            if (stray && k == 3) begin
                bus.q_wstrobe_i = 1;
                #1 check({nm, " stray ic_strobe"}, bus.ic_strobe, 0);
                @(negedge clk);
                bus.q_wstrobe_i = 0;
            end
            if (!is_d) bus.q_wstrobe_i = 1;
            else if (wr) bus.q_rstrobe_d = 1;
            else bus.q_wstrobe_d = 1;
            if (stray && k == 5) bus.q_wstrobe_i = 1;
            #1;
            routed = !is_d ? bus.ic_strobe : (wr ? bus.dc_wr_strobe : bus.dc_rd_strobe);
            if (routed) seen++;
            if (stray && k == 5) check({nm, " ic_strobe beside d strobe"}, bus.ic_strobe, 0);
            @(negedge clk);
            bus.q_wstrobe_i = 0; bus.q_wstrobe_d = 0; bus.q_rstrobe_d = 0;
            if (k == 0) check({nm, " q_req drop"}, bus.q_req, 0);
            if (k < n - 1 && (bus.ic_done || bus.dc_done)) early = 1;
        end
        check({nm, " strobes routed"}, seen, n);
        check({nm, " early done"}, early, 0);
        check({nm, " done"}, is_d ? {bus.dc_done, bus.ic_done} : {bus.ic_done, bus.dc_done}, 2'b10);
        if (is_d) bus.dc_req = 0; else bus.ic_req = 0;
        @(negedge clk);
        check({nm, " done/q_req after pulse"}, {bus.ic_done, bus.dc_done, bus.q_req}, 3'b000);
        if (rerise) begin if (is_d) bus.dc_req = 1; else bus.ic_req = 1; end
        @(negedge clk);
        check({nm, " q_req guard"}, bus.q_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;

        //          is_d wr mem  addr         lat i_d wr  mem  paddr
        vecs[0] = '{0, 1, 2'd0, 22'h012345, 2, 1, 0, 2'd0, 22'h012345};
        vecs[1] = '{1, 0, 2'd1, 22'h03ABCD, 0, 0, 0, 2'd1, 22'h03ABCD};
        vecs[2] = '{1, 1, 2'd2, 22'h000001, 0, 0, 1, 2'd2, 22'h000001};
        vecs[3] = '{0, 1, 2'd3, 22'h3FFFFF, 0, 1, 0, 2'd3, 22'h3FFFFF};
        vecs[4] = '{1, 1, 2'd0, 22'h000000, 0, 0, 1, 2'd0, 22'h000000};

        clear_inputs();

        // single-requester transactions; row 0 starts right at reset release
        do_reset("t1");
        for (int i = 0; i < 5; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            bus.dc_write = vecs[i].wr;
            if (vecs[i].is_d) begin
                bus.dc_addr = vecs[i].addr;  bus.dc_mem = vecs[i].mem;
                bus.ic_addr = ~vecs[i].addr; bus.ic_mem = ~vecs[i].mem;
                bus.dc_req  = 1;
            end else begin
                bus.ic_addr = vecs[i].addr;  bus.ic_mem = vecs[i].mem;
                bus.dc_addr = ~vecs[i].addr; bus.dc_mem = ~vecs[i].mem;
                bus.ic_req  = 1;
            end
            wait_qreq(nm, lat);
            check({nm, " latency"}, lat, vecs[i].lat);
            check({nm, " q_i_d"}, bus.q_i_d, vecs[i].exp_i_d);
            check({nm, " q_write"}, bus.q_write, vecs[i].exp_wr);
            check({nm, " q_mem"}, bus.q_mem, vecs[i].exp_mem);
            check({nm, " q_paddr"}, bus.q_paddr, vecs[i].exp_paddr);
            do_xfer(nm, vecs[i].is_d, vecs[i].wr, 8, 0, 0);
        end

        // D writeback and I fill raised together: D first, I after guard
        clear_inputs();
        do_reset("t2");
        bus.dc_req = 1; bus.dc_write = 1; bus.dc_mem = 2'd2; bus.dc_addr = 22'h0000AA;
        bus.ic_req = 1; bus.ic_mem = 2'd1; bus.ic_addr = 22'h000055;
        wait_qreq("t2 d", lat);
        check("t2 d q_i_d", bus.q_i_d, 0);
        check("t2 d q_write", bus.q_write, 1);
        check("t2 d q_mem", bus.q_mem, 2);
        do_xfer("t2 d", 1, 1, 8, 0, 0);
        wait_qreq("t2 i", lat);
        check("t2 i latency", lat, 0);
        check("t2 i q_i_d", bus.q_i_d, 1);
        check("t2 i q_write", bus.q_write, 0);
        check("t2 i q_paddr", bus.q_paddr, 22'h000055);
        do_xfer("t2 i", 0, 0, 8, 0, 0);

        // continuous D pressure with I pending: D, D, I, D, D, I
        clear_inputs();
        do_reset("t3");
        bus.dc_req = 1; bus.ic_req = 1;
        for (int g = 0; g < 6; g++) begin
            bit exp_d;
            string nm;
            exp_d = (g % 3) != 2;
            nm = $sformatf("t3 grant%0d", g);
            wait_qreq(nm, lat);
            check({nm, " q_i_d"}, bus.q_i_d, !exp_d);
            do_xfer(nm, exp_d, 0, 8, 1, 0);
        end
        bus.dc_req = 0; bus.ic_req = 0;

        // config write raised mid D read waits for guard, then precedes next grant
        clear_inputs();
        do_reset("t4");
        bus.dc_req = 1; bus.dc_addr = 22'h001234;
        wait_qreq("t4 d0", lat);
        bus.cfg_req = 1; bus.cfg_addr = ROM_MODE_REG; bus.cfg_data = 8'h01;
        base = regw_cnt;
        do_xfer("t4 d0", 1, 0, 8, 1, 0);
        check("t4 no reg write during xfer", regw_cnt - base, 0);
        check("t4 reg write idle", bus.q_reg_write, 0);
        @(negedge clk);
        check("t4 cfg cycle", {bus.q_reg_write, bus.cfg_ack, bus.q_reg_addr, bus.q_reg_data, bus.q_req},
              {1'b1, 1'b1, 4'd3, 8'h01, 1'b0});
        bus.cfg_req = 0;
        wait_qreq("t4 d1", lat);
        check("t4 d1 latency", lat, 1);
        check("t4 reg write count", regw_cnt - base, 1);
        check("t4 d1 q_i_d", bus.q_i_d, 0);
        do_xfer("t4 d1", 1, 0, 8, 0, 0);

        // reset in the middle of a D read: async clear, fresh 8-strobe transaction after
        clear_inputs();
        do_reset("t5");
        bus.dc_req = 1; bus.dc_mem = 2'd3; bus.dc_addr = 22'h2AAAAA;
        wait_qreq("t5 d0", lat);
        for (int k = 0; k < 3; k++) begin
            bus.q_wstrobe_d = 1;
            @(negedge clk);
            bus.q_wstrobe_d = 0;
        end
        check("t5 fields before reset", {bus.q_mem, bus.q_paddr}, {2'd3, 22'h2AAAAA});
        bus.q_wstrobe_d = 1;
        reset_n = 0;
        #1 check("t5 async reset outputs", outs(), 64'd0);
        @(negedge clk);
        bus.q_wstrobe_d = 0;
        check("t5 no done in reset", bus.dc_done, 0);
        @(negedge clk);
        check("t5 no done in reset 2", bus.dc_done, 0);
        reset_n = 1;
        wait_qreq("t5 d1", lat);
        check("t5 d1 latency", lat, 2);
        do_xfer("t5 d1", 1, 0, 8, 0, 0);

        // stray I strobes in IDLE and during a D transaction
        clear_inputs();
        do_reset("t6");
        repeat (3) @(negedge clk);
        bus.q_wstrobe_i = 1;
        #1 check("t6 idle stray", bus.ic_strobe, 0);
        @(negedge clk);
        check("t6 idle stray 2", {bus.ic_strobe, bus.q_req}, 2'b00);
        bus.q_wstrobe_i = 0;
        bus.dc_req = 1; bus.dc_addr = 22'h000777;
        wait_qreq("t6 d", lat);
        check("t6 d latency", lat, 0);
        do_xfer("t6 d", 1, 0, 8, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
